booth_operand_sequencer: RTL and testbench

Upstream driver and result collector for the radix-4 Booth multiplier (`RadixBooth`). It buffers signed operand pairs in a small FIFO, issues them one at a time with a multi-cycle `start` pulse, and waits a fixed latency because the multiplier has no done flag. It then captures the 64-bit product and presents it on a valid/ready output port. It converts the multiplier's start/fixed-latency protocol into streaming handshakes for the datapath above it.

---
 rtl/booth_seq_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/booth_operand_sequencer.sv | 152 +++++++++++++++
 tb/tb_booth_operand_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_seq_pkg.sv
// Shared types and default sizing for the Booth operand sequencer and its bench.
package booth_seq_pkg;

   localparam int DEFAULT_N          = 32;
   localparam int DEFAULT_DEPTH      = 4;
   localparam int DEFAULT_START_HOLD = 2;
   localparam int DEFAULT_MUL_LAT    = 20;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [DEFAULT_N-1:0] a;
      logic [DEFAULT_N-1:0] b;
   } operand_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: push/pop same cycle allowed, read data is the current head (no read latency).
// Pushes while full and pops while empty are ignored; reset is synchronous active-low.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/booth_operand_sequencer.sv
// Queues operand pairs, drives the Booth multiplier with a held start pulse, and returns products on valid/ready.
// Result appears START_HOLD+MUL_LAT+2 cycles after a pop; out_ready low parks the FSM in DONE.
module booth_operand_sequencer
   import booth_seq_pkg::*;
#(
   parameter int N          = DEFAULT_N,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int START_HOLD = DEFAULT_START_HOLD,
   parameter int MUL_LAT    = DEFAULT_MUL_LAT
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   output logic           mul_start,
   output logic           mul_enable,
   output logic           mul_reset,
   input  logic [2*N-1:0] mul_product,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_product,
   output logic           busy
);

   localparam int HOLD_W = $clog2(START_HOLD) + 1;
   localparam int WAIT_W = $clog2(MUL_LAT) + 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   state_t              state;
   state_t              state_nxt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [WAIT_W-1:0]   wait_cnt;

   logic                fifo_push;
   logic                fifo_pop;
   logic [2*N-1:0]      fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;

   logic                pop_req;
   logic                end_hold;
   logic                do_capture;
   logic                do_release;

   assign mul_enable = enable;
   assign mul_reset  = ~reset;
   // No look-ahead on a same-cycle pop: a full FIFO refuses even if it is draining.
   assign in_ready   = reset && enable && !fifo_full;
   assign fifo_push  = in_valid && in_ready;
   assign fifo_pop   = pop_req && enable;
   assign busy       = (state != S_IDLE) || (fifo_count != '0);

   sync_fifo #(
      .WIDTH (2*N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data ({in_a, in_b}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         state <= S_IDLE;
      else if (enable)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pop_req    = 1'b0;
      end_hold   = 1'b0;
      do_capture = 1'b0;
      do_release = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop_req   = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (hold_cnt == HOLD_W'(START_HOLD - 1)) begin
               end_hold  = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_W'(MUL_LAT - 1))
               state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            do_capture = 1'b1;
            state_nxt  = S_DONE;
         end
         S_DONE: begin
            if (out_valid && out_ready) begin
               do_release = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The multiplier has no done flag, so the product is sampled purely on elapsed cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mul_a       <= '0;
         mul_b       <= '0;
         mul_start   <= 1'b0;
         hold_cnt    <= '0;
         wait_cnt    <= '0;
         out_valid   <= 1'b0;
         out_product <= '0;
      end else if (enable) begin
         if (pop_req) begin
            mul_a     <= fifo_head[2*N-1:N];
            mul_b     <= fifo_head[N-1:0];
            mul_start <= 1'b1;
            hold_cnt  <= '0;
         end
         if (state == S_ISSUE)
            hold_cnt <= hold_cnt + HOLD_W'(1);
         if (end_hold) begin
            mul_start <= 1'b0;
            wait_cnt  <= '0;
         end
         if (state == S_WAIT)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         if (do_capture) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
         end
         if (do_release)
            out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Bench for booth_operand_sequencer with a behavioural signed multiplier standing in for RadixBooth.
module tb_booth_operand_sequencer;
   import booth_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_start;
   logic        mul_enable;
   logic        mul_reset;
   logic [63:0] mul_product;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_product;
   logic        busy;

   always #5 clk = ~clk;

   booth_operand_sequencer #(
      .N          (32),
      .DEPTH      (4),
      .START_HOLD (2),
      .MUL_LAT    (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_start   (mul_start),
      .mul_enable  (mul_enable),
      .mul_reset   (mul_reset),
      .mul_product (mul_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy)
   );

   // Stand-in multiplier: registers the product while start is high, frozen by mul_enable.
   logic [63:0] prod_q;
   assign mul_product = prod_q;
   always @(posedge clk) begin
      if (mul_reset)
         prod_q <= '0;
      else if (mul_enable && mul_start)
         prod_q <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
   end

   typedef struct {
      operand_t    op;
      logic [63:0] p;
   } vec_t;

   vec_t        tbl [9];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          start_cnt = 0;
   logic [63:0] sb [$];
   logic [63:0] in_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: record at accept, compare at handshake.
   always @(negedge clk) begin
      if (mul_start)
         start_cnt++;
      if (in_valid && in_ready)
         sb.push_back(in_exp);
      if (out_valid && out_ready && enable) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h with no pending entry", out_product);
         end else begin
            check("result", out_product, sb.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input vec_t v);
      bit ok = 1'b0;
      in_a     = v.op.a;
      in_b     = v.op.b;
      in_exp   = v.p;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(input int k, output int lat);
      bit ok = 1'b0;
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok)
         lat = cyc - k;
      else begin
         total++;
         bad++;
         $display("FAIL valid_timeout: out_valid stayed %b, expected 1", out_valid);
      end
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 1500; i++) begin
         if (sb.size() == 0)
            break;
         @(negedge clk);
      end
      check("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int          k;
      int          lat;
      int          hi_cnt;
      logic [63:0] held;

      tbl[0] = '{'{32'h00087234, 32'h00000348}, 64'h000000001BB6BAA0};
      tbl[1] = '{'{32'h50647236, 32'hB887CAAF}, 64'hE98E647F4142AEEA};
      tbl[2] = '{'{32'hFFFFFEFD, 32'h00087234}, 64'hFFFFFFFFF7747564};
      tbl[3] = '{'{32'hFFFFFEFD, 32'hFFFFFEFD}, 64'h0000000000010609};
      tbl[4] = '{'{32'hB887CAAF, 32'h00000001}, 64'hFFFFFFFFB887CAAF};
      tbl[5] = '{'{32'h00000348, 32'h00087234}, 64'h000000001BB6BAA0};
      tbl[6] = '{'{32'h00000000, 32'h50647236}, 64'h0000000000000000};
      tbl[7] = '{'{32'h00000001, 32'h50647236}, 64'h0000000050647236};
      tbl[8] = '{'{32'hFFFFFFFF, 32'hFFFFFFFF}, 64'h0000000000000001};

      reset     = 1'b0;
      enable    = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_exp    = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_product", out_product, 64'd0);
      check("rst_mul_start", 64'(mul_start), 64'd0);
      check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mul_reset", 64'(mul_reset), 64'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // Single operation: latency and start pulse width.
      start_cnt = 0;
      send(tbl[0]);
      k = cyc;
      wait_valid(k, lat);
      check("latency_single", 64'(lat), 64'd24);
      wait_empty();
      check("start_width", 64'(start_cnt), 64'd2);
      @(posedge clk);
      #1;

      // Park a result in DONE, then fill the FIFO behind it.
      out_ready = 1'b0;
      send(tbl[5]);
      wait_valid(cyc, lat);
      @(posedge clk);
      #1;
      for (int i = 1; i <= 4; i++)
         send(tbl[i]);
      @(negedge clk);
      check("in_ready_full", 64'(in_ready), 64'd0);
      check("busy_full", 64'(busy), 64'd1);
      held = out_product;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("hold_product", out_product, held);
         check("hold_no_start", 64'(mul_start), 64'd0);
         check("hold_valid", 64'(out_valid), 64'd1);
      end

      // Fifth push offered while full; it must wait for a free slot.
      @(posedge clk);
      #1;
      in_a     = tbl[8].op.a;
      in_b     = tbl[8].op.b;
      in_exp   = tbl[8].p;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fifth_blocked", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            k = 1;
            break;
         end
      end
      check("fifth_accepted", 64'(k), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_empty();
      @(posedge clk);
      #1;

      // Freeze for 10 cycles during WAIT.
      send(tbl[6]);
      k = cyc;
      repeat (10) @(posedge clk);
      #1 enable = 1'b0;
      repeat (10) @(posedge clk);
      #1 enable = 1'b1;
      wait_valid(k, lat);
      check("latency_frozen", 64'(lat), 64'd34);
      wait_empty();
      @(posedge clk);
      #1;

      // Reset mid-WAIT with two operands still queued.
      send(tbl[1]);
      send(tbl[2]);
      send(tbl[3]);
      repeat (8) @(posedge clk);
      #1;
      check("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_mul_ab", {mul_a, mul_b}, 64'd0);
      check("mid_rst_mul_start", 64'(mul_start), 64'd0);
      check("mid_rst_out", {63'd0, out_valid} | out_product, 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      check("mid_rst_mul_reset", 64'(mul_reset), 64'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      hi_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || busy || mul_start)
            hi_cnt++;
      end
      check("post_rst_quiet", 64'(hi_cnt), 64'd0);
      @(posedge clk);
      #1;
      send(tbl[7]);
      wait_empty();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
